// File: rtl/neuron_scheduler_pkg.sv
// qec_nn_pkg: shared FSM state type, default layer geometry and the ReLU/saturation helper
package qec_nn_pkg;
  localparam int N_INPUTS_DEF    = 4;
  localparam int WEIGHT_BITS_DEF = 3;
  localparam int INPUT_BITS_DEF  = 3;
  localparam int SUM_BITS_DEF    = 9;
  localparam int N_NEURONS_DEF   = 8;
  localparam int OUT_BITS_DEF    = 3;
  localparam int BW_CORR_DEF     = 0;
  localparam int ADDR_W  = N_NEURONS_DEF > 1 ? $clog2(N_NEURONS_DEF) : 1;
  localparam int ROW_W   = (N_INPUTS_DEF + 1) * WEIGHT_BITS_DEF;
  localparam int OUT_MAX = 2 ** OUT_BITS_DEF - 1;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, CAPTURE, DONE} state_t;
  function automatic logic [OUT_BITS_DEF-1:0] relu_sat(input logic signed [SUM_BITS_DEF-1:0] sum);
    return sum[SUM_BITS_DEF-1] ? '0 :
           |sum[SUM_BITS_DEF-2:OUT_BITS_DEF] ? OUT_BITS_DEF'(OUT_MAX) : sum[OUT_BITS_DEF-1:0];
  endfunction
endpackage

// File: rtl/neuron_scheduler_pp_gen.sv
// pp_gen: AND array forming every activation-bit x weight-bit partial product for the tree
//   x  : packed activations, activation k at [k*INPUT_BITS +: INPUT_BITS]
//   w  : packed weights, weight k at [k*WEIGHT_BITS +: WEIGHT_BITS]
//   pp : bit k*INPUT_BITS*WEIGHT_BITS + j*INPUT_BITS + i = x_k[i] & w_k[j]
module pp_gen
  import qec_nn_pkg::*;
#(
  parameter int N_INPUTS    = N_INPUTS_DEF,
  parameter int INPUT_BITS  = INPUT_BITS_DEF,
  parameter int WEIGHT_BITS = WEIGHT_BITS_DEF
) (
  input  logic [N_INPUTS*INPUT_BITS-1:0]             x,
  input  logic [N_INPUTS*WEIGHT_BITS-1:0]            w,
  output logic [N_INPUTS*INPUT_BITS*WEIGHT_BITS-1:0] pp
);
  genvar k, j, i;
  for (k = 0; k < N_INPUTS; k++) begin : g_k
    for (j = 0; j < WEIGHT_BITS; j++) begin : g_j
      for (i = 0; i < INPUT_BITS; i++) begin : g_i
        assign pp[k*INPUT_BITS*WEIGHT_BITS + j*INPUT_BITS + i] = x[k*INPUT_BITS+i] & w[k*WEIGHT_BITS+j];
      end
    end
  end
endmodule

// File: rtl/neuron_scheduler.sv
// neuron_scheduler: time-multiplexes one combinational wallace_tree across all neurons of a layer
//   clk, rst_n        : clock, asynchronous active-low reset
//   clr               : synchronous abort back to IDLE (out_data kept)
//   in_valid/in_ready/in_data     : activation vector handshake, accepted only in IDLE
//   mem_rd_en/mem_addr/mem_rd_data: synchronous weight memory, row = {bias, w[N_INPUTS-1..0]}, 1-cycle latency
//   tree_multiplicants/tree_bias/tree_baugh_wooley/tree_sum: wallace_tree operands and result
//   out_valid/out_ready/out_data  : layer result handshake, neuron n at [n*OUT_BITS +: OUT_BITS]
//   busy              : high whenever a layer is in progress or awaiting hand-off
// The activation uses the package relu_sat, whose widths are the package defaults.
module neuron_scheduler
  import qec_nn_pkg::*;
#(
  parameter int N_INPUTS    = N_INPUTS_DEF,
  parameter int WEIGHT_BITS = WEIGHT_BITS_DEF,
  parameter int INPUT_BITS  = INPUT_BITS_DEF,
  parameter int SUM_BITS    = SUM_BITS_DEF,
  parameter int N_NEURONS   = N_NEURONS_DEF,
  parameter int OUT_BITS    = OUT_BITS_DEF,
  parameter int BW_CORR     = BW_CORR_DEF,
  localparam int AW = N_NEURONS > 1 ? $clog2(N_NEURONS) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       clr,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [N_INPUTS*INPUT_BITS-1:0]             in_data,
  output logic                                       mem_rd_en,
  output logic [AW-1:0]                              mem_addr,
  input  logic [N_INPUTS*WEIGHT_BITS+WEIGHT_BITS-1:0] mem_rd_data,
  output logic [N_INPUTS*INPUT_BITS*WEIGHT_BITS-1:0] tree_multiplicants,
  output logic [WEIGHT_BITS-1:0]                     tree_bias,
  output logic [SUM_BITS-INPUT_BITS-1:0]             tree_baugh_wooley,
  input  logic [SUM_BITS-1:0]                        tree_sum,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0]              out_data,
  output logic                                       busy
);
  state_t state, state_n;
  logic [AW-1:0] n;
  logic [N_INPUTS*INPUT_BITS-1:0] x_q;
  logic [N_INPUTS*WEIGHT_BITS-1:0] w_q;
  logic [WEIGHT_BITS-1:0] b_q;
  logic last;
  assign last = n == AW'(N_NEURONS - 1);
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = in_valid ? FETCH : IDLE;
      FETCH:   state_n = LOAD;
      LOAD:    state_n = CAPTURE;
      CAPTURE: state_n = last ? DONE : FETCH;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
    if (clr) state_n = IDLE;
    in_ready  = state == IDLE;
    mem_rd_en = state == FETCH;
    out_valid = state == DONE;
    busy      = state != IDLE;
    mem_addr  = n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      n        <= '0;
      x_q      <= '0;
      w_q      <= '0;
      b_q      <= '0;
      out_data <= '0;
    end else begin
      state <= state_n;
      if (!clr && state == IDLE && in_valid) begin
        x_q      <= in_data;
        n        <= '0;
        out_data <= '0;
      end
      if (!clr && state == LOAD) begin
        w_q <= mem_rd_data[N_INPUTS*WEIGHT_BITS-1:0];
        b_q <= mem_rd_data[N_INPUTS*WEIGHT_BITS +: WEIGHT_BITS];
      end
      // operands were loaded a cycle earlier, so tree_sum is settled here
      if (!clr && state == CAPTURE) begin
        out_data[n*OUT_BITS +: OUT_BITS] <= relu_sat(tree_sum);
        if (!last) n <= n + 1'b1;
      end
    end
  end
  assign tree_bias         = b_q;
  assign tree_baugh_wooley = (SUM_BITS-INPUT_BITS)'(BW_CORR);
  pp_gen #(
    .N_INPUTS(N_INPUTS),
    .INPUT_BITS(INPUT_BITS),
    .WEIGHT_BITS(WEIGHT_BITS)
  ) u_pp_gen (
    .x(x_q),
    .w(w_q),
    .pp(tree_multiplicants)
  );
endmodule

// File: tb/tb_neuron_scheduler.sv
// tb_neuron_scheduler: directed scenarios against a behavioural tree and weight memory
module tb_neuron_scheduler;
  logic clk = 1'b0;
  logic rst_n, clr, in_valid, in_ready, mem_rd_en, out_valid, out_ready, busy;
  logic [11:0] in_data;
  logic [2:0] mem_addr;
  logic [14:0] mem_rd_data = '0;
  logic [35:0] tree_multiplicants;
  logic [2:0] tree_bias;
  logic [5:0] tree_baugh_wooley;
  logic [8:0] tree_sum;
  logic [23:0] out_data;
  logic [14:0] rows [8];
  int checks = 0, errors = 0;
  int cyc = 0, rd_cnt = 0, acc_cnt = 0;
  int rd_addr [256];
  int rd_t [256];
  int acc_t [64];
  int s;
  localparam logic [11:0] X_ONES  = {4{3'd1}};
  localparam logic [11:0] X_MIX   = {3'd0, 3'd0, 3'd2, 3'd1};
  localparam logic [23:0] EXP_MIX = {3'd5, 3'd3, 3'd0, 3'd2, 3'd7, 3'd2, 3'd0, 3'd3};
  localparam logic [23:0] EXP_SEQ = {3'd7, 3'd7, 3'd4, 3'd0, 3'd7, 3'd7, 3'd4, 3'd0};

  always #5 clk = ~clk;

  neuron_scheduler dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .tree_multiplicants(tree_multiplicants), .tree_bias(tree_bias),
    .tree_baugh_wooley(tree_baugh_wooley), .tree_sum(tree_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  // behavioural tree: weighted sum of partial-product bits plus signed bias
  always_comb begin
    s = int'($signed(tree_bias));
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 3; j++)
        for (int i = 0; i < 3; i++)
          if (tree_multiplicants[k*9 + j*3 + i]) s = s + (1 << (i + j));
  end
  assign tree_sum = s[8:0];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) begin
      mem_rd_data <= rows[mem_addr];
      if (rd_cnt < 256) begin
        rd_addr[rd_cnt] <= int'(mem_addr);
        rd_t[rd_cnt] <= cyc;
      end
      rd_cnt <= rd_cnt + 1;
    end
    if (in_valid && in_ready) begin
      if (acc_cnt < 64) acc_t[acc_cnt] <= cyc;
      acc_cnt <= acc_cnt + 1;
    end
  end

  function automatic logic [14:0] row(input logic [2:0] b, w3, w2, w1, w0);
    return {b, w3, w2, w1, w0};
  endfunction

  task automatic set_mixed_rows;
    rows[0] = row(3'd0, 3'd0, 3'd0, 3'd1, 3'd1);
    rows[1] = row(3'd4, 3'd0, 3'd0, 3'd0, 3'd0);
    rows[2] = row(3'd0, 3'd0, 3'd0, 3'd1, 3'd0);
    rows[3] = row(3'd0, 3'd3, 3'd3, 3'd3, 3'd3);
    rows[4] = row(3'd4, 3'd0, 3'd0, 3'd3, 3'd0);
    rows[5] = row(3'd7, 3'd0, 3'd0, 3'd0, 3'd1);
    rows[6] = row(3'd3, 3'd0, 3'd0, 3'd0, 3'd0);
    rows[7] = row(3'd3, 3'd0, 3'd0, 3'd0, 3'd2);
  endtask

  task automatic send_vec(input logic [11:0] v);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    in_data = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!out_valid && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    if (!out_valid) c = -1;
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, busy, out_valid, mem_rd_en} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 1000", {in_ready, busy, out_valid, mem_rd_en});
    end
    checks++;
    if (mem_addr !== 3'd0) begin
      errors++;
      $display("FAIL reset_addr got %0d exp 0", mem_addr);
    end
    checks++;
    if (out_data !== 24'd0) begin
      errors++;
      $display("FAIL reset_out_data got %h exp 0", out_data);
    end
    checks++;
    if ({tree_multiplicants, tree_bias, tree_baugh_wooley} !== 45'd0) begin
      errors++;
      $display("FAIL reset_tree got %h/%h/%h exp 0", tree_multiplicants, tree_bias, tree_baugh_wooley);
    end
  endtask

  task automatic test_saturate;
    int c;
    for (int i = 0; i < 8; i++) rows[i] = row(3'd1, 3'd2, 3'd2, 3'd2, 3'd2);
    send_vec(X_ONES);
    wait_done(c);
    checks++;
    if (c !== 24) begin
      errors++;
      $display("FAIL sat_latency got %0d exp 24", c);
    end
    checks++;
    if (out_data !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL sat_out_data got %h exp ffffff", out_data);
    end
    handshake;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL sat_release got %b exp 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_mixed;
    int c;
    set_mixed_rows;
    send_vec(X_MIX);
    wait_done(c);
    checks++;
    if (out_data !== EXP_MIX) begin
      errors++;
      $display("FAIL mixed_out_data got %h exp %h", out_data, EXP_MIX);
    end
    handshake;
  endtask

  task automatic test_sequence;
    int c, base;
    for (int i = 0; i < 8; i++) rows[i] = row(3'd0, 3'(i & 3), 3'(i & 3), 3'(i & 3), 3'(i & 3));
    out_ready = 1'b1;
    base = rd_cnt;
    send_vec(X_ONES);
    wait_done(c);
    checks++;
    if (c !== 24) begin
      errors++;
      $display("FAIL seq_latency got %0d exp 24", c);
    end
    checks++;
    if (out_data !== EXP_SEQ) begin
      errors++;
      $display("FAIL seq_out_data got %h exp %h", out_data, EXP_SEQ);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL seq_release got %b exp 0", out_valid);
    end
    checks++;
    if (rd_cnt - base !== 8) begin
      errors++;
      $display("FAIL seq_rd_count got %0d exp 8", rd_cnt - base);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_addr[base+i] !== i) begin
        errors++;
        $display("FAIL seq_addr%0d got %0d exp %0d", i, rd_addr[base+i], i);
      end
      if (i > 0) begin
        checks++;
        if (rd_t[base+i] - rd_t[base+i-1] !== 3) begin
          errors++;
          $display("FAIL seq_spacing%0d got %0d exp 3", i, rd_t[base+i] - rd_t[base+i-1]);
        end
      end
    end
  endtask

  task automatic test_stall;
    int c;
    send_vec(X_ONES);
    wait_done(c);
    for (int t = 0; t < 10; t++) begin
      in_valid = (t == 4);
      in_data = X_MIX;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b101) begin
        errors++;
        $display("FAIL stall_ctrl%0d got %b exp 101", t, {out_valid, in_ready, busy});
      end
      checks++;
      if (out_data !== EXP_SEQ) begin
        errors++;
        $display("FAIL stall_data%0d got %h exp %h", t, out_data, EXP_SEQ);
      end
    end
    in_valid = 1'b0;
    handshake;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL stall_release got %b exp 01", {out_valid, in_ready});
    end
    checks++;
    if (out_data !== EXP_SEQ) begin
      errors++;
      $display("FAIL stall_retain got %h exp %h", out_data, EXP_SEQ);
    end
    send_vec(X_ONES);
    checks++;
    if ({busy, out_data} !== {1'b1, 24'd0}) begin
      errors++;
      $display("FAIL stall_reaccept got %b/%h exp 1/0", busy, out_data);
    end
    wait_done(c);
    handshake;
  endtask

  task automatic test_back_to_back;
    int b, t;
    b = acc_cnt;
    out_ready = 1'b1;
    in_data = X_ONES;
    in_valid = 1'b1;
    t = 0;
    while (acc_cnt < b + 3 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    checks++;
    if (acc_cnt < b + 3) begin
      errors++;
      $display("FAIL b2b_accepts got %0d exp 3", acc_cnt - b);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_t[b+i] - acc_t[b+i-1] !== 26) begin
          errors++;
          $display("FAIL b2b_period%0d got %0d exp 26", i, acc_t[b+i] - acc_t[b+i-1]);
        end
      end
    end
    t = 0;
    while (busy && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got %b exp 0", busy);
    end
  endtask

  task automatic test_clr;
    int c, t, base;
    logic seen;
    set_mixed_rows;
    send_vec(X_MIX);
    t = 0;
    while (!(mem_rd_en && mem_addr == 3'd4) && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b010) begin
      errors++;
      $display("FAIL clr_abort got %b exp 010", {busy, in_ready, out_valid});
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid | mem_rd_en;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL clr_quiet got %b exp 0", seen);
    end
    base = rd_cnt;
    send_vec(X_MIX);
    wait_done(c);
    checks++;
    if (c !== 24 || out_data !== EXP_MIX) begin
      errors++;
      $display("FAIL clr_rerun got %0d/%h exp 24/%h", c, out_data, EXP_MIX);
    end
    checks++;
    if (rd_addr[base] !== 0) begin
      errors++;
      $display("FAIL clr_first_addr got %0d exp 0", rd_addr[base]);
    end
    handshake;
  endtask

  task automatic test_async_reset;
    int c, t, base;
    set_mixed_rows;
    send_vec(X_MIX);
    t = 0;
    while (!(mem_rd_en && mem_addr == 3'd2) && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_rd_en, busy, in_ready, out_valid, mem_addr} !== 7'b0010000) begin
      errors++;
      $display("FAIL arst_ctrl got %b exp 0010000", {mem_rd_en, busy, in_ready, out_valid, mem_addr});
    end
    checks++;
    if ({out_data, tree_multiplicants, tree_bias} !== 63'd0) begin
      errors++;
      $display("FAIL arst_data got %h/%h/%h exp 0", out_data, tree_multiplicants, tree_bias);
    end
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL arst_release got %b exp 10", {in_ready, busy});
    end
    base = rd_cnt;
    send_vec(X_MIX);
    wait_done(c);
    checks++;
    if (out_data !== EXP_MIX || rd_addr[base] !== 0) begin
      errors++;
      $display("FAIL arst_rerun got %h/%0d exp %h/0", out_data, rd_addr[base], EXP_MIX);
    end
    handshake;
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) rows[i] = '0;
    test_reset;
    test_saturate;
    test_mixed;
    test_sequence;
    test_stall;
    test_back_to_back;
    test_clr;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
